serial_mod_checker: RTL and testbench

SERIAL_MOD_CHECKER -- requirements
Module: serial_mod_checker

---
 rtl/mod_pkg.sv | 21 ++
 rtl/mod_step.sv | 51 +++++
 rtl/serial_mod_checker.sv | 92 +++++++++
 tb/tb_serial_mod_checker.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mod_pkg.sv
// Shared constants and helpers for the serial modulo checker.
// Holds the divisor range limits, the bit-order encodings and a constant clog2.
package mod_pkg;

   localparam int unsigned MOD_MIN = 2;
   localparam int unsigned MOD_MAX = 16;

   localparam logic MODE_MSB = 1'b0;
   localparam logic MODE_LSB = 1'b1;

   // Number of bits needed to hold values 0..v-1
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 31; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mod_step.sv
// One serial step of the running remainder for either bit order.
// Purely combinational; the reduction is a single conditional subtract since every operand is below 2N.
module mod_step
   import mod_pkg::*;
#(
   parameter int unsigned MODULUS = 3,
   parameter int unsigned REM_W   = 2
) (
   input  logic [REM_W-1:0] i_rem,
   input  logic [REM_W-1:0] i_wgt,
   input  logic             i_bit,
   input  logic             i_mode,
   input  logic             i_first,
   output logic [REM_W-1:0] o_rem_next_c,
   output logic [REM_W-1:0] o_wgt_next_c
);

   localparam int unsigned SUM_W = REM_W + 2;
   localparam logic [SUM_W-1:0] N_S = SUM_W'(MODULUS);

   function automatic logic [REM_W-1:0] reduce(input logic [SUM_W-1:0] s);
      if (s >= N_S) return REM_W'(s - N_S);
      else          return REM_W'(s);
   endfunction

   logic [REM_W-1:0] w_rem_base;
   logic [REM_W-1:0] w_wgt_base;
   logic [SUM_W-1:0] w_rem_ext;
   logic [SUM_W-1:0] w_wgt_ext;
   logic [SUM_W-1:0] w_sum;

   // A first beat starts from the empty-frame state regardless of history
   always_comb begin
      w_rem_base   = i_first ? '0 : i_rem;
      w_wgt_base   = i_first ? REM_W'(1) : i_wgt;
      w_rem_ext    = SUM_W'(w_rem_base);
      w_wgt_ext    = SUM_W'(w_wgt_base);
      w_sum        = '0;
      o_rem_next_c = w_rem_base;
      o_wgt_next_c = w_wgt_base;
      if (i_mode == MODE_LSB) begin
         w_sum        = w_rem_ext + (i_bit ? w_wgt_ext : '0);
         o_rem_next_c = reduce(w_sum);
         o_wgt_next_c = reduce(w_wgt_ext << 1);
      end else begin
         w_sum        = (w_rem_ext << 1) + SUM_W'(i_bit);
         o_rem_next_c = reduce(w_sum);
      end
   end

endmodule

// File: rtl/serial_mod_checker.sv
// Serial divisibility checker: tracks the value of a bit stream modulo MODULUS.
// Holds the frame state registers; the arithmetic lives in mod_step.
module serial_mod_checker
   import mod_pkg::*;
#(
   parameter int unsigned MODULUS = 3,
   parameter int unsigned CNT_W   = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   input  logic                          in_bit,
   input  logic                          in_first,
   input  logic                          in_lsb_first,
   output logic                          out_valid,
   output logic [clog2(MODULUS)-1:0]     remainder,
   output logic                          divisible,
   output logic [CNT_W-1:0]              bit_count,
   output logic                          count_ovf
);

   localparam int unsigned REM_W = clog2(MODULUS);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   if (MODULUS < MOD_MIN || MODULUS > MOD_MAX) begin : g_bad_modulus
      $error("serial_mod_checker: MODULUS out of range");
   end

   logic [REM_W-1:0] r_rem;
   logic [REM_W-1:0] r_wgt;
   logic             r_mode;
   logic             r_valid;
   logic             r_div;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;

   logic             w_mode;
   logic [REM_W-1:0] w_rem_next;
   logic [REM_W-1:0] w_wgt_next;

   // Bit order is only taken from the first beat of a frame
   assign w_mode = in_first ? in_lsb_first : r_mode;

   mod_step #(
      .MODULUS (MODULUS),
      .REM_W   (REM_W)
   ) u_step (
      .i_rem        (r_rem),
      .i_wgt        (r_wgt),
      .i_bit        (in_bit),
      .i_mode       (w_mode),
      .i_first      (in_first),
      .o_rem_next_c (w_rem_next),
      .o_wgt_next_c (w_wgt_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rem   <= '0;
         r_wgt   <= REM_W'(1);
         r_mode  <= MODE_MSB;
         r_valid <= 1'b0;
         r_div   <= 1'b1;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_rem  <= w_rem_next;
            r_wgt  <= w_wgt_next;
            r_mode <= w_mode;
            r_div  <= (w_rem_next == '0);
            // Count saturates; a beat beyond the last countable one marks overflow
            if (in_first) begin
               r_cnt <= CNT_W'(1);
               r_ovf <= 1'b0;
            end else if (r_cnt == CNT_MAX) begin
               r_ovf <= 1'b1;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign out_valid = r_valid;
   assign remainder = r_rem;
   assign divisible = r_div;
   assign bit_count = r_cnt;
   assign count_ovf = r_ovf;

endmodule

// File: tb/tb_serial_mod_checker.sv
// Bench for serial_mod_checker: four configurations share one stimulus stream;
// a frame-level model fills a scoreboard that a negedge monitor drains.
module tb_serial_mod_checker;

   typedef struct packed {
      logic [3:0][7:0] rem;
      logic [3:0]      div;
      logic [3:0][7:0] cnt;
      logic [3:0]      ovf;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic in_valid = 1'b0;
   logic in_bit = 1'b0;
   logic in_first = 1'b0;
   logic in_lsb_first = 1'b0;

   logic       v0, v1, v2, v3;
   logic [1:0] rem0, rem3;
   logic [2:0] rem1, rem2;
   logic       d0, d1, d2, d3;
   logic [7:0] c0, c1, c2;
   logic [2:0] c3;
   logic       o0, o1, o2, o3;

   logic       a_valid [4];
   logic [7:0] a_rem   [4];
   logic       a_div   [4];
   logic [7:0] a_cnt   [4];
   logic       a_ovf   [4];

   int cfg_n    [4] = '{3, 5, 7, 3};
   int cfg_cmax [4] = '{255, 255, 255, 7};

   int   n_chk  = 0;
   int   n_fail = 0;
   logic mon_en = 1'b0;
   logic exp_valid = 1'b0;
   logic exp_rst = 1'b0;
   exp_t sb[$];

   logic m_bits[$];
   logic m_lsb = 1'b0;
   int   m_cnt = 0;
   exp_t m_e;
   exp_t p_e;

   always #5 clk = ~clk;

   serial_mod_checker #(.MODULUS(3), .CNT_W(8)) u_n3 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .in_first(in_first),
      .in_lsb_first(in_lsb_first), .out_valid(v0), .remainder(rem0), .divisible(d0),
      .bit_count(c0), .count_ovf(o0));
   serial_mod_checker #(.MODULUS(5), .CNT_W(8)) u_n5 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .in_first(in_first),
      .in_lsb_first(in_lsb_first), .out_valid(v1), .remainder(rem1), .divisible(d1),
      .bit_count(c1), .count_ovf(o1));
   serial_mod_checker #(.MODULUS(7), .CNT_W(8)) u_n7 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .in_first(in_first),
      .in_lsb_first(in_lsb_first), .out_valid(v2), .remainder(rem2), .divisible(d2),
      .bit_count(c2), .count_ovf(o2));
   serial_mod_checker #(.MODULUS(3), .CNT_W(3)) u_c3 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .in_first(in_first),
      .in_lsb_first(in_lsb_first), .out_valid(v3), .remainder(rem3), .divisible(d3),
      .bit_count(c3), .count_ovf(o3));

   assign a_valid[0] = v0;  assign a_valid[1] = v1;  assign a_valid[2] = v2;  assign a_valid[3] = v3;
   assign a_rem[0] = 8'(rem0); assign a_rem[1] = 8'(rem1); assign a_rem[2] = 8'(rem2); assign a_rem[3] = 8'(rem3);
   assign a_div[0] = d0;  assign a_div[1] = d1;  assign a_div[2] = d2;  assign a_div[3] = d3;
   assign a_cnt[0] = c0;  assign a_cnt[1] = c1;  assign a_cnt[2] = c2;  assign a_cnt[3] = 8'(c3);
   assign a_ovf[0] = o0;  assign a_ovf[1] = o1;  assign a_ovf[2] = o2;  assign a_ovf[3] = o3;

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[inst %0d] got %0d expected %0d at %0t", nm, k, act, exp, $time);
      end
   endtask

   // Value of the whole current frame modulo n, from the received bit list
   function automatic int frame_mod(input int n);
      int r = 0;
      int len = m_bits.size();
      for (int i = 0; i < len; i++) begin
         r = (r * 2 + int'(m_lsb ? m_bits[len-1-i] : m_bits[i])) % n;
      end
      return r;
   endfunction

   // Reference model: sees the same inputs the DUTs sample at each rising edge
   always @(posedge clk) begin
      exp_rst   = reset;
      exp_valid = 1'b0;
      if (reset) begin
         m_bits.delete();
         m_lsb = 1'b0;
         m_cnt = 0;
      end else if (in_valid) begin
         if (in_first) begin
            m_bits.delete();
            m_lsb = in_lsb_first;
            m_cnt = 0;
         end
         m_bits.push_back(in_bit);
         m_cnt++;
         for (int k = 0; k < 4; k++) begin
            int r;
            r = frame_mod(cfg_n[k]);
            m_e.rem[k] = 8'(r);
            m_e.div[k] = (r == 0);
            m_e.cnt[k] = 8'((m_cnt > cfg_cmax[k]) ? cfg_cmax[k] : m_cnt);
            m_e.ovf[k] = (m_cnt > cfg_cmax[k]);
         end
         sb.push_back(m_e);
         exp_valid = 1'b1;
      end
   end

   // Monitor: checks valid timing every cycle and drains the scoreboard on each output
   always @(negedge clk) begin
      if (mon_en) begin
         logic any_v;
         any_v = 1'b0;
         for (int k = 0; k < 4; k++) begin
            chk("out_valid", k, 32'(a_valid[k]), 32'(exp_valid));
            if (a_valid[k] === 1'b1) any_v = 1'b1;
            if (exp_rst) begin
               chk("rst_rem", k, 32'(a_rem[k]), 32'd0);
               chk("rst_div", k, 32'(a_div[k]), 32'd1);
               chk("rst_cnt", k, 32'(a_cnt[k]), 32'd0);
               chk("rst_ovf", k, 32'(a_ovf[k]), 32'd0);
            end
         end
         if (any_v) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 0, 32'd1, 32'd0);
            end else begin
               p_e = sb.pop_front();
               for (int k = 0; k < 4; k++) begin
                  if (a_valid[k] === 1'b1) begin
                     chk("remainder", k, 32'(a_rem[k]), 32'(p_e.rem[k]));
                     chk("divisible", k, 32'(a_div[k]), 32'(p_e.div[k]));
                     chk("bit_count", k, 32'(a_cnt[k]), 32'(p_e.cnt[k]));
                     chk("count_ovf", k, 32'(a_ovf[k]), 32'(p_e.ovf[k]));
                  end
               end
            end
         end
      end
   end

   task automatic cyc(input logic v, input logic b, input logic f, input logic l, input logic r);
      in_valid = v; in_bit = b; in_first = f; in_lsb_first = l; reset = r;
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic b, input logic f, input logic l);
      cyc(1'b1, b, f, l, 1'b0);
   endtask

   initial begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      mon_en = 1'b1;
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // 6 MSB-first, N=3
      beat(1, 1, 0); beat(1, 0, 0); beat(0, 0, 0);
      chk("ex6_rem", 0, 32'(rem0), 32'd0);
      chk("ex6_div", 0, 32'(d0), 32'd1);
      chk("ex6_cnt", 0, 32'(c0), 32'd3);

      // 5 LSB-first, N=5, with in_lsb_first toggled mid-frame; back-to-back start
      beat(1, 1, 1); chk("ex5_step1", 1, 32'(rem1), 32'd1);
      beat(0, 0, 0); chk("ex5_step2", 1, 32'(rem1), 32'd1);
      beat(1, 0, 0); chk("ex5_step3", 1, 32'(rem1), 32'd0);
      chk("ex5_div", 1, 32'(d1), 32'd1);

      // 43 MSB-first, N=7, two idle cycles after beat 3
      beat(1, 1, 0); beat(0, 0, 1); beat(1, 0, 1);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      beat(0, 0, 0); beat(1, 0, 0); beat(1, 0, 0);
      chk("ex43_rem", 2, 32'(rem2), 32'd1);
      chk("ex43_cnt", 2, 32'(c2), 32'd6);

      // Reset mid-frame, then a frame continued without a first beat
      beat(1, 1, 0); beat(0, 0, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      beat(1, 0, 1); beat(1, 0, 1);
      chk("rstcont_rem", 0, 32'(rem0), 32'd0);
      chk("rstcont_cnt", 0, 32'(c0), 32'd2);

      // 9 ones into the 3-bit counter
      beat(1, 1, 0);
      for (int i = 0; i < 8; i++) beat(1, 0, 0);
      chk("sat_cnt", 3, 32'(c3), 32'd7);
      chk("sat_ovf", 3, 32'(o3), 32'd1);
      chk("sat_rem", 3, 32'(rem3), 32'd1);
      beat(0, 1, 0);
      chk("sat_clr_ovf", 3, 32'(o3), 32'd0);
      chk("sat_clr_cnt", 3, 32'(c3), 32'd1);

      // Long random frame past the 8-bit counter limit
      for (int i = 0; i < 259; i++) beat(1'($urandom), 0, 1'($urandom));
      chk("long_ovf", 0, 32'(o0), 32'd1);
      chk("long_cnt", 0, 32'(c0), 32'd255);

      // Random traffic: gaps, frame starts, mode flips and occasional resets
      for (int i = 0; i < 600; i++) begin
         cyc(1'($urandom_range(3, 0) != 0), 1'($urandom), 1'($urandom_range(5, 0) == 0),
             1'($urandom), 1'($urandom_range(49, 0) == 0));
      end

      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("sb_empty", 0, 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
